// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor. One 4-bit CLA group is
//   evaluated per pipeline stage. The carry passes between stages through a
//   register. A single global enable stalls every stage together.
//
//   Ports
//     clk, rst_n          rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready   operand handshake (in_ready = pipeline enable)
//     a, b, cin, sub      operands; sub=1 computes a - b - cin
//     out_valid/out_ready result handshake
//     s, cout, ovf, zero  registered result and flags (cout = NOT borrow on sub)
module cla_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = WIDTH / GROUP;

   // 4-bit carry-lookahead group: returns {carry_out, sum[3:0]}.
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic       c1, c2, c3, c4;
      g  = x & y;
      p  = x ^ y;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c4, p ^ {c3, c2, c1, c0}};
   endfunction

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic             ovf_q;
   logic             zero_q;

   assign en       = out_ready | ~out_valid;
   assign in_ready = en;

   // Subtraction as a + ~b + ~cin.
   assign b_eff = sub ? ~b : b;
   assign c0    = sub ? ~cin : cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int OPW = WIDTH - GROUP * k;   // operand bits still to be summed
      localparam int SW  = GROUP * (k + 1);     // sum bits known after this stage

      logic [OPW-1:0] op_a;
      logic [OPW-1:0] op_b;
      logic           c_in;
      logic           v_in;
      logic [4:0]     r;
      logic [SW-1:0]  sum_d;
      logic [SW-1:0]  sum_q;
      logic           c_q;
      logic           v_q;

      if (k == 0) begin : g_src
         assign op_a  = a;
         assign op_b  = b_eff;
         assign c_in  = c0;
         assign v_in  = in_valid;
         assign sum_d = r[3:0];
      end else begin : g_src
         assign op_a  = g_stg[k-1].g_fwd.a_q;
         assign op_b  = g_stg[k-1].g_fwd.b_q;
         assign c_in  = g_stg[k-1].c_q;
         assign v_in  = g_stg[k-1].v_q;
         assign sum_d = {r[3:0], g_stg[k-1].sum_q};
      end

      assign r = cla4(op_a[GROUP-1:0], op_b[GROUP-1:0], c_in);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            sum_q <= '0;
         end else if (en) begin
            v_q   <= v_in;
            c_q   <= r[4];
            sum_q <= sum_d;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [OPW-GROUP-1:0] a_q;
         logic [OPW-GROUP-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en) begin
               a_q <= op_a[OPW-1:GROUP];
               b_q <= op_b[OPW-1:GROUP];
            end
         end
      end else begin : g_last
         // The carry into the MSB is recovered as s_msb ^ a_msb ^ b_msb.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (en) begin
               ovf_q  <= r[4] ^ (sum_d[SW-1] ^ op_a[GROUP-1] ^ op_b[GROUP-1]);
               zero_q <= (sum_d == '0);
            end
         end
      end
   end

   assign s         = g_stg[STAGES-1].sum_q;
   assign cout      = g_stg[STAGES-1].c_q;
   assign out_valid = g_stg[STAGES-1].v_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder
//   Self-checking bench for cla_pipe_adder (WIDTH=16). Results are predicted
//   with plain integer arithmetic and kept in an in-order scoreboard queue.
module tb_cla_pipe_adder;

   localparam int W      = 16;
   localparam int STAGES = 4;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      logic         z;
   } res_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] s;
   logic         cout;
   logic         ovf;
   logic         zero;

   int   checks = 0;
   int   errors = 0;
   int   n_deliv = 0;
   logic seen_rdy;
   res_t exp_q[$];

   cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   // Reference: integer arithmetic on unsigned and signed interpretations.
   function automatic res_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic ic, input logic is);
      res_t r;
      int   ua, ub, uc, sa, sb, tot, sres;
      ua = int'(ia);
      ub = int'(ib);
      uc = int'(ic);
      sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
      sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
      if (!is) begin
         tot  = ua + ub + uc;
         r.c  = (tot >= (1 << W));
         sres = sa + sb + uc;
      end else begin
         tot  = ua - ub - uc + (1 << W);
         r.c  = (ua >= ub + uc);
         sres = sa - sb - uc;
      end
      r.s = tot[W-1:0];
      r.o = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
      r.z = (r.s == '0);
      return r;
   endfunction

   // One clock: drive at the falling edge, score just after, wait for next fall.
   task automatic cyc(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, input logic is, input logic ordy);
      res_t e;
      in_valid  = v;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = is;
      out_ready = ordy;
      #1;
      seen_rdy = in_ready;
      if (out_valid === 1'b1) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL spurious_out_valid observed=1 required=0");
         end
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            checks++;
            assert ({s, cout, ovf, zero} === {e.s, e.c, e.o, e.z}) else begin
               errors++;
               $error("FAIL result observed s=%h c=%b o=%b z=%b required s=%h c=%b o=%b z=%b",
                      s, cout, ovf, zero, e.s, e.c, e.o, e.z);
            end
            if (ordy) begin
               void'(exp_q.pop_front());
               n_deliv++;
            end
         end
      end
      if (v && (in_ready === 1'b1)) exp_q.push_back(model(ia, ib, ic, is));
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   // Single operation into an empty pipe: checks latency and the listed result.
   task automatic directed(input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic ic, input logic is,
                           input logic [W-1:0] es, input logic ec,
                           input logic eo, input logic ez);
      int lat;
      cyc(1'b1, ia, ib, ic, is, 1'b1);
      lat = 1;
      while ((out_valid !== 1'b1) && (lat < 20)) begin
         cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         lat++;
      end
      checks++;
      assert (lat == STAGES) else begin
         errors++;
         $error("FAIL latency observed=%0d required=%0d", lat, STAGES);
      end
      checks++;
      assert ({s, cout, ovf, zero} === {es, ec, eo, ez}) else begin
         errors++;
         $error("FAIL directed observed s=%h c=%b o=%b z=%b required s=%h c=%b o=%b z=%b",
                s, cout, ovf, zero, es, ec, eo, ez);
      end
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int base;

      // Reset state
      @(negedge clk);
      #1;
      checks++;
      assert ({out_valid, s, cout, ovf, zero, in_ready} === {1'b0, 16'h0000, 3'b000, 1'b1})
      else begin
         errors++;
         $error("FAIL reset_state observed v=%b s=%h c=%b o=%b z=%b rdy=%b required v=0 s=0000 c=0 o=0 z=0 rdy=1",
                out_valid, s, cout, ovf, zero, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Listed vectors
      directed(16'h000A, 16'h0005, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
      directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      directed(16'h0005, 16'h000A, 1'b0, 1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0);
      directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      directed(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      directed(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

      // Back-to-back: 8 ops, results on 8 consecutive cycles
      base = n_deliv;
      for (int j = 0; j < 12; j++) begin
         if (j < 8) cyc(1'b1, W'(j), W'(j), 1'b0, 1'b0, 1'b1);
         else       cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         checks++;
         assert (seen_rdy === 1'b1) else begin
            errors++;
            $error("FAIL b2b_in_ready observed=%b required=1", seen_rdy);
         end
         checks++;
         assert ((n_deliv - base) == ((j >= 4) ? j - 3 : 0)) else begin
            errors++;
            $error("FAIL b2b_delivered observed=%0d required=%0d", n_deliv - base,
                   (j >= 4) ? j - 3 : 0);
         end
      end

      // Stall with a full pipeline
      for (int j = 0; j < 6; j++) cyc(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), 1'b1);
      for (int j = 0; j < 3; j++) begin
         cyc(1'($urandom), pick(), pick(), 1'($urandom), 1'($urandom), 1'b0);
         checks++;
         assert (seen_rdy === 1'b0) else begin
            errors++;
            $error("FAIL stall_in_ready observed=%b required=0", seen_rdy);
         end
         checks++;
         assert (out_valid === 1'b1) else begin
            errors++;
            $error("FAIL stall_out_valid observed=%b required=1", out_valid);
         end
      end
      idle(8);
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL stall_drain observed=%0d pending required=0", exp_q.size());
      end

      // Asynchronous reset with 3 ops in flight
      for (int j = 0; j < 3; j++) cyc(1'b1, pick(), pick(), 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      assert ({out_valid, s, cout, ovf, zero} === {1'b0, 16'h0000, 3'b000}) else begin
         errors++;
         $error("FAIL async_reset observed v=%b s=%h c=%b o=%b z=%b required all 0",
                out_valid, s, cout, ovf, zero);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      base = n_deliv;
      idle(6);
      checks++;
      assert (n_deliv == base) else begin
         errors++;
         $error("FAIL post_reset_results observed=%0d required=0", n_deliv - base);
      end

      // Randomised traffic with random backpressure
      for (int j = 0; j < 300; j++)
         cyc(($urandom_range(0, 3) != 0), pick(), pick(), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) != 0));
      idle(10);
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL final_drain observed=%0d pending required=0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
